// File: rtl/cbc_job_sequencer.sv
// rtl/cbc_job_sequencer.sv - job-level controller in front of the AES CBC/ECB engine
//
// Purpose:
//   Takes one job descriptor at a time, drives the engine control inputs,
//   launches the AXI read master, waits for the write master to finish and
//   returns one status word per job. A RUN-state watchdog and a check that
//   the read master reported completion produce the error codes.
//
// Ports:
//   aclk, areset_n            clock, asynchronous active-low reset
//   job_valid / job_ready     descriptor handshake
//   job_mode, job_cbc_mode,   descriptor fields, latched on accept
//   job_iv, job_words,
//   job_rd_addr, job_wr_addr
//   eng_*                     engine controls, hold the latched descriptor
//   eng_op_start              one-cycle engine start pulse
//   rmst_req, rmst_xfer_*     read-master launch pulse, address and byte size
//   rmst_done, wmst_done      read/write master completion pulses
//   sts_valid / sts_ready     status handshake, sts_code carries the result
//   busy                      high whenever a job is in flight or reporting
//   jobs_done                 count of accepted status words (wraps)

module cbc_job_sequencer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
  parameter int          CNT_W          = 16
) (
  input  logic             aclk,
  input  logic             areset_n,

  input  logic             job_valid,
  output logic             job_ready,
  input  logic             job_mode,
  input  logic             job_cbc_mode,
  input  logic [127:0]     job_iv,
  input  logic [9:0]       job_words,
  input  logic [63:0]      job_rd_addr,
  input  logic [63:0]      job_wr_addr,

  output logic             eng_mode,
  output logic             eng_cbc_mode,
  output logic [127:0]     eng_iv,
  output logic [9:0]       eng_words_num,
  output logic [63:0]      eng_write_addr,
  output logic             eng_op_start,

  output logic             rmst_req,
  output logic [63:0]      rmst_xfer_addr,
  output logic [63:0]      rmst_xfer_size,
  input  logic             rmst_done,
  input  logic             wmst_done,

  output logic             sts_valid,
  input  logic             sts_ready,
  output logic [1:0]       sts_code,

  output logic             busy,
  output logic [CNT_W-1:0] jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  localparam logic [1:0] CODE_OK      = 2'd0;
  localparam logic [1:0] CODE_BAD_LEN = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;
  localparam logic [1:0] CODE_NO_RD   = 2'd3;

  localparam logic       WD_ENABLED   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] WD_LAST     = TIMEOUT_CYCLES - 32'd1;

  state_t           r_state;
  logic             r_job_ready;
  logic             r_mode;
  logic             r_cbc_mode;
  logic [127:0]     r_iv;
  logic [9:0]       r_words;
  logic [63:0]      r_rd_addr;
  logic [63:0]      r_wr_addr;
  logic             r_launch;
  logic             r_rd_seen;
  logic [31:0]      r_wd;
  logic             r_sts_valid;
  logic [1:0]       r_sts_code;
  logic             r_busy;
  logic [CNT_W-1:0] r_jobs_done;

  logic             w_accept;
  logic             w_wd_expired;

  assign w_accept     = job_valid & r_job_ready;
  assign w_wd_expired = WD_ENABLED && (r_wd == WD_LAST);

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= S_IDLE;
      r_job_ready <= 1'b0;
      r_mode      <= 1'b0;
      r_cbc_mode  <= 1'b0;
      r_iv        <= '0;
      r_words     <= '0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_launch    <= 1'b0;
      r_rd_seen   <= 1'b0;
      r_wd        <= '0;
      r_sts_valid <= 1'b0;
      r_sts_code  <= '0;
      r_busy      <= 1'b0;
      r_jobs_done <= '0;
    end else begin
      r_launch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Descriptor fields only change here, so eng_* are glitch-free mid-job.
            r_mode      <= job_mode;
            r_cbc_mode  <= job_cbc_mode;
            r_iv        <= job_iv;
            r_words     <= job_words;
            r_rd_addr   <= job_rd_addr;
            r_wr_addr   <= job_wr_addr;
            r_job_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_rd_seen   <= 1'b0;
            if (job_words == 10'd0) begin
              r_state     <= S_REPORT;
              r_sts_valid <= 1'b1;
              r_sts_code  <= CODE_BAD_LEN;
            end else begin
              r_state  <= S_START;
              r_launch <= 1'b1;
            end
          end else begin
            r_job_ready <= 1'b1;
          end
        end

        S_START: begin
          r_state <= S_RUN;
          if (WD_ENABLED) begin
            r_wd <= '0;
          end
        end

        S_RUN: begin
          if (wmst_done) begin
            // Completion beats a same-cycle watchdog expiry.
            r_state     <= S_REPORT;
            r_sts_valid <= 1'b1;
            r_sts_code  <= (r_rd_seen || rmst_done) ? CODE_OK : CODE_NO_RD;
          end else if (w_wd_expired) begin
            r_state     <= S_REPORT;
            r_sts_valid <= 1'b1;
            r_sts_code  <= CODE_TIMEOUT;
          end else begin
            if (rmst_done) begin
              r_rd_seen <= 1'b1;
            end
            if (WD_ENABLED && (r_wd != 32'hFFFF_FFFF)) begin
              r_wd <= r_wd + 32'd1;
            end
          end
        end

        S_REPORT: begin
          if (sts_ready) begin
            r_state     <= S_IDLE;
            r_sts_valid <= 1'b0;
            r_sts_code  <= '0;
            r_busy      <= 1'b0;
            r_job_ready <= 1'b1;
            r_jobs_done <= r_jobs_done + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready      = r_job_ready;
  assign eng_mode       = r_mode;
  assign eng_cbc_mode   = r_cbc_mode;
  assign eng_iv         = r_iv;
  assign eng_words_num  = r_words;
  assign eng_write_addr = r_wr_addr;
  assign eng_op_start   = r_launch;
  assign rmst_req       = r_launch;
  assign rmst_xfer_addr = r_rd_addr;
  assign rmst_xfer_size = {50'd0, r_words, 4'd0};
  assign sts_valid      = r_sts_valid;
  assign sts_code       = r_sts_code;
  assign busy           = r_busy;
  assign jobs_done      = r_jobs_done;

endmodule

// File: tb/tb_cbc_job_sequencer.sv
// tb/tb_cbc_job_sequencer.sv - self-checking bench for cbc_job_sequencer

module tb_cbc_job_sequencer;

  localparam int TO = 16;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset_n = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic          job_mode = 1'b0;
  logic          job_cbc_mode = 1'b0;
  logic [127:0]  job_iv = '0;
  logic [9:0]    job_words = '0;
  logic [63:0]   job_rd_addr = '0;
  logic [63:0]   job_wr_addr = '0;
  logic          eng_mode;
  logic          eng_cbc_mode;
  logic [127:0]  eng_iv;
  logic [9:0]    eng_words_num;
  logic [63:0]   eng_write_addr;
  logic          eng_op_start;
  logic          rmst_req;
  logic [63:0]   rmst_xfer_addr;
  logic [63:0]   rmst_xfer_size;
  logic          rmst_done = 1'b0;
  logic          wmst_done = 1'b0;
  logic          sts_valid;
  logic          sts_ready = 1'b0;
  logic [1:0]    sts_code;
  logic          busy;
  logic [CW-1:0] jobs_done;

  int checks = 0;
  int failures = 0;

  cbc_job_sequencer #(.TIMEOUT_CYCLES(32'(TO)), .CNT_W(CW)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
    .job_cbc_mode(job_cbc_mode), .job_iv(job_iv), .job_words(job_words),
    .job_rd_addr(job_rd_addr), .job_wr_addr(job_wr_addr),
    .eng_mode(eng_mode), .eng_cbc_mode(eng_cbc_mode), .eng_iv(eng_iv),
    .eng_words_num(eng_words_num), .eng_write_addr(eng_write_addr),
    .eng_op_start(eng_op_start), .rmst_req(rmst_req),
    .rmst_xfer_addr(rmst_xfer_addr), .rmst_xfer_size(rmst_xfer_size),
    .rmst_done(rmst_done), .wmst_done(wmst_done),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_code(sts_code),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Job-level reference: a job walks launch -> waiting -> reporting, counting
  // how many cycles it has waited and how many read completions it has seen.
  int            m_phase;      // 0 idle, 1 launch cycle, 2 waiting, 3 reporting
  logic          m_ready;
  logic          m_mode, m_cbc;
  logic [127:0]  m_iv;
  int            m_words;
  logic [63:0]   m_rd, m_wr;
  int            m_waited;
  int            m_rd_pulses;
  int            m_code;
  int            m_jobs;

  always begin
    @(posedge aclk);
    #1;
    if (!areset_n) begin
      m_phase = 0; m_ready = 1'b0; m_mode = 1'b0; m_cbc = 1'b0; m_iv = '0;
      m_words = 0; m_rd = '0; m_wr = '0; m_waited = 0; m_rd_pulses = 0;
      m_code = 0; m_jobs = 0;
    end else begin
      case (m_phase)
        0: begin
          if (job_valid && m_ready) begin
            m_mode = job_mode; m_cbc = job_cbc_mode; m_iv = job_iv;
            m_words = int'(job_words); m_rd = job_rd_addr; m_wr = job_wr_addr;
            m_rd_pulses = 0;
            m_ready = 1'b0;
            if (m_words == 0) begin m_phase = 3; m_code = 1; end
            else m_phase = 1;
          end else begin
            m_ready = 1'b1;
          end
        end
        1: begin m_phase = 2; m_waited = 0; end
        2: begin
          if (wmst_done) begin
            m_code = (m_rd_pulses > 0 || rmst_done) ? 0 : 3;
            m_phase = 3;
          end else if (m_waited + 1 == TO) begin
            m_code = 2;
            m_phase = 3;
          end else begin
            m_waited++;
            if (rmst_done) m_rd_pulses++;
          end
        end
        default: begin
          if (sts_ready) begin
            m_jobs = (m_jobs + 1) % (1 << CW);
            m_phase = 0;
            m_ready = 1'b1;
          end
        end
      endcase
    end
    check("cmp_job_ready", 128'(job_ready), 128'(m_ready));
    check("cmp_busy", 128'(busy), 128'(m_phase != 0));
    check("cmp_op_start", 128'(eng_op_start), 128'(m_phase == 1));
    check("cmp_rmst_req", 128'(rmst_req), 128'(m_phase == 1));
    check("cmp_sts_valid", 128'(sts_valid), 128'(m_phase == 3));
    if (m_phase == 3) check("cmp_sts_code", 128'(sts_code), 128'(m_code));
    check("cmp_eng_ctl", {eng_mode, eng_cbc_mode, eng_words_num}, {m_mode, m_cbc, 10'(m_words)});
    check("cmp_eng_iv", eng_iv, m_iv);
    check("cmp_addrs", {eng_write_addr, rmst_xfer_addr}, {m_wr, m_rd});
    check("cmp_xfer_size", 128'(rmst_xfer_size), 128'(64'(m_words) * 64'd16));
    check("cmp_jobs_done", 128'(jobs_done), 128'(m_jobs));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  // Returns at the negedge just after the accepting clock edge (START cycle).
  task automatic send_job(input logic mode, input logic cbc, input logic [127:0] iv,
                          input logic [9:0] words, input logic [63:0] rd, input logic [63:0] wr);
    int n = 0;
    job_mode = mode; job_cbc_mode = cbc; job_iv = iv; job_words = words;
    job_rd_addr = rd; job_wr_addr = wr;
    while (!job_ready && n < 50) begin @(negedge aclk); n++; end
    if (!job_ready) check("job_ready_wait", 128'(job_ready), 128'd1);
    job_valid = 1'b1;
    @(negedge aclk);
    job_valid = 1'b0;
  endtask

  task automatic pulse_rmst;
    rmst_done = 1'b1; @(negedge aclk); rmst_done = 1'b0;
  endtask

  task automatic pulse_wmst;
    wmst_done = 1'b1; @(negedge aclk); wmst_done = 1'b0;
  endtask

  task automatic take_status;
    int n = 0;
    while (!sts_valid && n < 50) begin @(negedge aclk); n++; end
    if (!sts_valid) check("sts_valid_wait", 128'(sts_valid), 128'd1);
    sts_ready = 1'b1; @(negedge aclk); sts_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int n;
    #2;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_job_ready", 128'(job_ready), 128'd0);
    check("rst_sts_valid", 128'(sts_valid), 128'd0);
    check("rst_eng_iv", eng_iv, 128'd0);
    tick(3);
    areset_n = 1'b1;
    tick(2);

    // 1: ECB encrypt, 4 words
    send_job(1'b1, 1'b0, 128'h0, 10'd4, 64'h1000, 64'h2000);
    check("t1_op_start", 128'(eng_op_start), 128'd1);
    check("t1_rmst_req", 128'(rmst_req), 128'd1);
    check("t1_xfer_size", 128'(rmst_xfer_size), 128'd64);
    check("t1_xfer_addr", 128'(rmst_xfer_addr), 128'h1000);
    check("t1_wr_addr", 128'(eng_write_addr), 128'h2000);
    tick(1);
    check("t1_op_start_off", 128'(eng_op_start), 128'd0);
    pulse_rmst();
    tick(1);
    pulse_wmst();
    check("t1_sts_valid", 128'(sts_valid), 128'd1);
    check("t1_sts_code", 128'(sts_code), 128'd0);
    take_status();
    check("t1_jobs_done", 128'(jobs_done), 128'd1);

    // 2: zero-length job
    send_job(1'b0, 1'b0, 128'h0, 10'd0, 64'h3000, 64'h4000);
    check("t2_no_start", 128'({eng_op_start, rmst_req}), 128'd0);
    check("t2_sts_valid", 128'(sts_valid), 128'd1);
    check("t2_sts_code", 128'(sts_code), 128'd1);
    take_status();
    check("t2_busy", 128'(busy), 128'd0);
    check("t2_jobs_done", 128'(jobs_done), 128'd2);

    // 3: watchdog, no write completion
    send_job(1'b1, 1'b1, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 10'd2, 64'h10, 64'h20);
    n = 0;
    while (!sts_valid && n < 100) begin
      @(negedge aclk); n++;
      check("t3_iv_hold", eng_iv, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);
    end
    check("t3_latency", 128'(n), 128'd17);
    check("t3_sts_code", 128'(sts_code), 128'd2);
    take_status();

    // 4: back-to-back CBC jobs, status held off 5 cycles
    send_job(1'b0, 1'b1, 128'hAAAA, 10'd1, 64'h100, 64'h200);
    tick(1);
    pulse_rmst();
    pulse_wmst();
    job_valid = 1'b1; job_iv = 128'hBBBB; job_words = 10'd3;
    for (int i = 0; i < 5; i++) begin
      check("t4_ready_low", 128'(job_ready), 128'd0);
      check("t4_iv_job1", eng_iv, 128'hAAAA);
      @(negedge aclk);
    end
    sts_ready = 1'b1; @(negedge aclk); sts_ready = 1'b0;
    check("t4_ready_high", 128'(job_ready), 128'd1);
    check("t4_iv_still1", eng_iv, 128'hAAAA);
    @(negedge aclk);
    job_valid = 1'b0;
    check("t4_iv_job2", eng_iv, 128'hBBBB);
    check("t4_start2", 128'(eng_op_start), 128'd1);
    tick(1);
    pulse_rmst();
    pulse_wmst();
    check("t4_code2", 128'(sts_code), 128'd0);
    take_status();
    check("t4_jobs_done", 128'(jobs_done), 128'd5);

    // 5a: stray read pulse in IDLE is ignored -> missing read completion
    pulse_rmst();
    send_job(1'b1, 1'b0, 128'h0, 10'd5, 64'h500, 64'h600);
    tick(2);
    pulse_wmst();
    check("t5_code3", 128'(sts_code), 128'd3);
    take_status();

    // 5b: write completion lands on the watchdog's final cycle
    send_job(1'b1, 1'b0, 128'h0, 10'd5, 64'h500, 64'h600);
    tick(2);
    pulse_rmst();
    tick(13);
    check("t5_not_yet", 128'(sts_valid), 128'd0);
    pulse_wmst();
    check("t5_tie_valid", 128'(sts_valid), 128'd1);
    check("t5_tie_code", 128'(sts_code), 128'd0);
    take_status();
    check("t5_jobs_done", 128'(jobs_done), 128'd7);

    // 6: asynchronous reset during RUN, then a normal job
    send_job(1'b1, 1'b1, 128'hC0DE, 10'd3, 64'h700, 64'h800);
    tick(3);
    areset_n = 1'b0;
    #1;
    check("t6_busy", 128'(busy), 128'd0);
    check("t6_sts_valid", 128'(sts_valid), 128'd0);
    check("t6_outs", {eng_iv}, 128'd0);
    check("t6_misc", 128'({job_ready, eng_mode, eng_cbc_mode, jobs_done, rmst_xfer_size}), 128'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    send_job(1'b0, 1'b1, 128'hF00D, 10'd1, 64'h900, 64'hA00);
    tick(1);
    pulse_rmst();
    pulse_wmst();
    check("t6_code", 128'(sts_code), 128'd0);
    take_status();
    check("t6_jobs_done", 128'(jobs_done), 128'd1);

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
